lat_mem: RTL and testbench

- Parametrised successor to the unified instruction/data memory on the multicycle core's bus.
- Adds configurable wait-state latency and a req/ready handshake.
- Adds per-byte write enables.
- Reports errors for out-of-range and misaligned accesses.
- Sits between the core's Adr/WriteData/MemWrite bus and storage, so the multicycle FSM can be exercised against slow memory.

---
 rtl/lat_mem.sv | 157 +++++++++++++++
 tb/tb_lat_mem.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lat_mem.sv
// Unified word memory with configurable wait states, a req/ready handshake,
// per-byte write enables, and error reporting for misaligned or out-of-range addresses.
module lat_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   wd,
  output logic [DATA_W-1:0]   rd,
  output logic                ready,
  output logic                err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                aerr_q, aerr_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   widx;
  logic                in_err;
  logic                fin;
  logic                f_we;
  logic [BE_W-1:0]     f_be;
  logic [DATA_W-1:0]   f_wd;
  logic [IDX_W-1:0]    f_idx;
  logic                f_err;
  logic                mem_wr;

  // Alignment is checked with a mask so DATA_W=8 (no offset bits) still works.
  assign widx   = a >> OFF;
  assign in_err = ((a & ADDR_W'(BE_W - 1)) != '0) || (widx >= ADDR_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    idx_d   = idx_q;
    aerr_d  = aerr_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    fin     = 1'b0;
    f_we    = we_q;
    f_be    = be_q;
    f_wd    = wd_q;
    f_idx   = idx_q;
    f_err   = aerr_q;

    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          we_d   = we;
          be_d   = be;
          wd_d   = wd;
          idx_d  = widx[IDX_W-1:0];
          aerr_d = in_err;
          cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) begin
            // Zero wait states: the access completes on its own accepting edge.
            fin     = 1'b1;
            f_we    = we;
            f_be    = be;
            f_wd    = wd;
            f_idx   = widx[IDX_W-1:0];
            f_err   = in_err;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      ready_d = 1'b1;
      err_d   = f_err;
      if (f_err) begin
        rd_d = '0;
      end else if (!f_we) begin
        rd_d = mem_q[f_idx];
      end
    end
  end

  assign mem_wr = fin && f_we && !f_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q   <= we_d;
    be_q   <= be_d;
    wd_q   <= wd_d;
    idx_q  <= idx_d;
    aerr_q <= aerr_d;
  end

  // Storage survives reset; a reset edge also suppresses any completing write.
  always_ff @(posedge clk) begin
    if (reset && mem_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (f_be[i]) mem_q[f_idx][8*i +: 8] <= f_wd[8*i +: 8];
      end
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_lat_mem.sv
// Directed bench for lat_mem: instances with LATENCY 2, 0 and 15 share the bus
// inputs and are selected by their own req lines.
`timescale 1ns/1ps
module tb_lat_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic        req2, req0, req15;
  logic [31:0] rd2, rd0, rd15;
  logic        ready2, ready0, ready15;
  logic        err2, err0, err15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lat_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rd2), .ready(ready2), .err(err2));

  lat_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rd0), .ready(ready0), .err(err0));

  lat_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(15)) u15 (
    .clk(clk), .reset(reset), .req(req15), .we(we), .be(be), .a(a), .wd(wd),
    .rd(rd15), .ready(ready15), .err(err15));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 access: ready must be low after E0 and E1, high after E2, low after E3.
  task automatic acc2(input string tag, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] bytes,
                      input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    we = w; a = addr; wd = data; be = bytes; req2 = 1'b1;
    tick;
    req2 = 1'b0; we = ~w; a = 32'hFFFF_FFFF; wd = ~data; be = ~bytes;
    chk({tag, ".rdy_e0"}, {31'd0, ready2}, 32'd0);
    tick;
    chk({tag, ".rdy_e1"}, {31'd0, ready2}, 32'd0);
    tick;
    chk({tag, ".rdy_e2"}, {31'd0, ready2}, 32'd1);
    chk({tag, ".err"}, {31'd0, err2}, {31'd0, exp_err});
    if (chk_rd) chk({tag, ".rd"}, rd2, exp_rd);
    tick;
    chk({tag, ".rdy_drop"}, {31'd0, ready2}, 32'd0);
    chk({tag, ".err_drop"}, {31'd0, err2}, 32'd0);
    if (chk_rd) chk({tag, ".rd_held"}, rd2, exp_rd);
  endtask

  // One LATENCY=15 access, optionally toggling req through the wait states.
  task automatic acc15(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, input logic toggle,
                       input logic chk_rd, input logic [31:0] exp_rd);
    int early;
    int extra;
    early = 0;
    extra = 0;
    we = w; a = addr; wd = data; be = 4'hF; req15 = 1'b1;
    tick;
    we = ~w; a = 32'h0000_0100; wd = ~data;
    for (int k = 1; k <= 14; k++) begin
      req15 = toggle ? k[0] : 1'b0;
      tick;
      if (ready15) early++;
    end
    req15 = toggle;
    tick;
    req15 = 1'b0;
    chk({tag, ".early"}, early, 32'd0);
    chk({tag, ".rdy_e15"}, {31'd0, ready15}, 32'd1);
    chk({tag, ".err"}, {31'd0, err15}, 32'd0);
    if (chk_rd) chk({tag, ".rd"}, rd15, exp_rd);
    for (int k = 0; k < 20; k++) begin
      tick;
      if (ready15) extra++;
    end
    chk({tag, ".extra"}, extra, 32'd0);
  endtask

  initial begin
    reset = 1'b0; req2 = 1'b0; req0 = 1'b0; req15 = 1'b0;
    we = 1'b0; be = 4'h0; a = 32'd0; wd = 32'd0;
    tick; tick; tick;
    reset = 1'b1;
    chk("rst.ready2", {31'd0, ready2}, 32'd0);
    chk("rst.err2", {31'd0, err2}, 32'd0);
    chk("rst.rd2", rd2, 32'd0);
    chk("rst.ready0", {31'd0, ready0}, 32'd0);
    chk("rst.rd0", rd0, 32'd0);
    chk("rst.ready15", {31'd0, ready15}, 32'd0);
    chk("rst.rd15", rd15, 32'd0);

    acc2("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'd0);
    acc2("rd_full", 1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    acc2("wr_be1", 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 1'b0, 1'b1, 32'hDEAD_BEEF);
    acc2("rd_be1", 1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF);
    acc2("wr_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF);
    acc2("rd_be0", 1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF);
    acc2("rd_oor", 1'b0, 32'h100, 32'd0, 4'b0000, 1'b1, 1'b1, 32'd0);
    acc2("rd_ok", 1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF);
    acc2("wr_oor", 1'b1, 32'h100, 32'h1111_1111, 4'b1111, 1'b1, 1'b1, 32'd0);
    acc2("wr_mis", 1'b1, 32'h12, 32'h2222_2222, 4'b1111, 1'b1, 1'b1, 32'd0);
    acc2("rd_after_err", 1'b0, 32'h10, 32'd0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF);

    acc2("wr_pre20", 1'b1, 32'h20, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0, 32'd0);
    we = 1'b1; a = 32'h20; wd = 32'h1234_5678; be = 4'hF; req2 = 1'b1;
    tick;
    req2 = 1'b0; reset = 1'b0;
    tick;
    chk("midrst.ready", {31'd0, ready2}, 32'd0);
    chk("midrst.rd", rd2, 32'd0);
    chk("midrst.err", {31'd0, err2}, 32'd0);
    reset = 1'b1;
    tick;
    chk("midrst.no_pulse1", {31'd0, ready2}, 32'd0);
    tick;
    chk("midrst.no_pulse2", {31'd0, ready2}, 32'd0);
    acc2("rd_post_rst", 1'b0, 32'h20, 32'd0, 4'b0000, 1'b0, 1'b1, 32'h0BAD_F00D);

    we = 1'b1; a = 32'h4; wd = 32'hCAFE_F00D; be = 4'hF; req0 = 1'b1;
    tick;
    chk("b2b.wr_ready", {31'd0, ready0}, 32'd1);
    chk("b2b.wr_err", {31'd0, err0}, 32'd0);
    chk("b2b.wr_rd_kept", rd0, 32'd0);
    we = 1'b0; wd = 32'd0;
    tick;
    chk("b2b.rd_ready", {31'd0, ready0}, 32'd1);
    chk("b2b.rd_data", rd0, 32'hCAFE_F00D);
    chk("b2b.rd_err", {31'd0, err0}, 32'd0);
    req0 = 1'b0;
    tick;
    chk("b2b.drop", {31'd0, ready0}, 32'd0);
    chk("b2b.held", rd0, 32'hCAFE_F00D);

    acc15("l15_wr", 1'b1, 32'h8, 32'h55AA_33CC, 1'b0, 1'b0, 32'd0);
    acc15("l15_rd", 1'b0, 32'h8, 32'd0, 1'b1, 1'b1, 32'h55AA_33CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
